// File: rtl/mem_pkg.sv
// Types and constants shared between the L1 controllers and the memory subsystem.
package mem_pkg;

  localparam int unsigned ADDR_W = 14;

  typedef enum logic [1:0] {
    CohI = 2'b00,
    CohM = 2'b01,
    CohS = 2'b10
  } coherency_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWb,
    StFill,
    StResp
  } l1_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/l1_tag_array.sv
// Direct-mapped line store: coherency state (async reset to I), tag and data per line.
module l1_tag_array
  import mem_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TAG_W     = 11,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output coherency_t        rd_state,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  coherency_t        wr_state,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  coherency_t        state_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) state_q[i] <= CohI;
    end else if (wr_en) begin
      state_q[wr_idx] <= wr_state;
    end
  end

  // Tag and data are deliberately left unreset; state I masks their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_state = state_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-back L1 controller bridging one CPU to one memory port.
// Optional statistics counters enabled with L1_CACHE_STATS_EN.
module l1_cache_ctrl #(
  parameter int unsigned DATA_SIZE = 2,
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned ADDR_W    = mem_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_SIZE*8-1:0] cpu_wdata,
  output logic [DATA_SIZE*8-1:0] cpu_rdata,
  output logic                   cpu_ready,
  output logic                   processor_req,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_SIZE*8-1:0] mem_write_data,
  input  logic [DATA_SIZE*8-1:0] mem_read_data,
  input  logic                   processor_resp
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic [31:0]            wb_count
`endif
);
  import mem_pkg::*;

  localparam int unsigned DATA_W = DATA_SIZE * 8;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;

  l1_state_t           state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                ready_d, preq_d, rd_req_d, wr_req_d;
  logic [DATA_W-1:0]   rdata_d, wb_data_d;
  logic [ADDR_W-1:0]   mem_addr_d;

  coherency_t          line_state, wr_state;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data, wr_data;
  logic                wr_en, hit;

  l1_tag_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W)
  ) u_tags (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_idx  (addr_q[IDX_W-1:0]),
    .rd_state(line_state),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (wr_en),
    .wr_idx  (addr_q[IDX_W-1:0]),
    .wr_state(wr_state),
    .wr_tag  (addr_q[ADDR_W-1:IDX_W]),
    .wr_data (wr_data)
  );

  assign hit = (line_state != CohI) && (line_tag == addr_q[ADDR_W-1:IDX_W]);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    rdata_d    = '0;
    preq_d     = 1'b0;
    rd_req_d   = 1'b0;
    wr_req_d   = 1'b0;
    mem_addr_d = '0;
    wb_data_d  = '0;
    wr_en      = 1'b0;
    wr_state   = CohI;
    wr_data    = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          state_d = StResp;
          ready_d = 1'b1;
          if (we_q) begin
            wr_en    = 1'b1;
            wr_state = CohM;
            wr_data  = wdata_q;
          end else begin
            rdata_d = line_data;
          end
        end else if (line_state == CohM) begin
          state_d    = StWb;
          preq_d     = 1'b1;
          wr_req_d   = 1'b1;
          mem_addr_d = {line_tag, addr_q[IDX_W-1:0]};
          wb_data_d  = line_data;
        end else begin
          state_d    = StFill;
          preq_d     = 1'b1;
          rd_req_d   = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      StWb: begin
        // Outputs fall to 0 on completion, giving the one-cycle gap before the fill.
        if (processor_resp) begin
          state_d = StFill;
        end else begin
          preq_d     = 1'b1;
          wr_req_d   = 1'b1;
          mem_addr_d = {line_tag, addr_q[IDX_W-1:0]};
          wb_data_d  = line_data;
        end
      end
      StFill: begin
        // A response is only meaningful once the read request is actually on the port.
        if (processor_req && processor_resp) begin
          state_d  = StResp;
          ready_d  = 1'b1;
          wr_en    = 1'b1;
          wr_state = we_q ? CohM : CohS;
          wr_data  = we_q ? wdata_q : mem_read_data;
          rdata_d  = we_q ? '0 : mem_read_data;
        end else begin
          preq_d     = 1'b1;
          rd_req_d   = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cpu_ready      <= 1'b0;
      cpu_rdata      <= '0;
      processor_req  <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      addr           <= '0;
      mem_write_data <= '0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cpu_ready      <= ready_d;
      cpu_rdata      <= rdata_d;
      processor_req  <= preq_d;
      mem_read_req   <= rd_req_d;
      mem_write_req  <= wr_req_d;
      addr           <= mem_addr_d;
      mem_write_data <= wb_data_d;
    end
  end

`ifdef L1_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state_q == StLookup && hit)  hit_count  <= sat_inc(hit_count);
      if (state_q == StLookup && !hit) miss_count <= sat_inc(miss_count);
      if (state_q == StWb && processor_resp) wb_count <= sat_inc(wb_count);
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: vector table, rdata scoreboard and a reactive memory model.
module tb_l1_cache_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        processor_req;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data = '0;
  logic        processor_resp = 1'b0;
`ifdef L1_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .processor_req (processor_req),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .addr          (addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .processor_resp(processor_resp)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .wb_count      (wb_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: word i resets to i+1; responds 1-3 cycles after seeing a request.
  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [15:0] d;
  } mop_t;

  logic [15:0] mem [16384];
  mop_t        log_q [$];

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i + 1);
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && processor_req) begin
        mop_t op;
        int   lat;
        chk("rw_exclusive", {31'd0, mem_read_req & mem_write_req}, 32'd0);
        op.we = mem_write_req;
        op.a  = addr;
        op.d  = mem_write_req ? mem_write_data : 16'h0;
        log_q.push_back(op);
        lat = $urandom_range(1, 3);
        repeat (lat - 1) begin
          @(posedge clk);
          #1;
        end
        if (op.we) mem[op.a] = op.d;
        mem_read_data  = mem[op.a];
        processor_resp = 1'b1;
        @(posedge clk);
        #1;
        processor_resp = 1'b0;
        mem_read_data  = $urandom;
      end
    end
  end

  // Scoreboard: expected rdata pushed on issue, popped on each cpu_ready pulse.
  logic [15:0] exp_q [$];

  always @(negedge clk) begin
    if (cpu_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got rdata %0h expected no response", cpu_rdata);
      end else begin
        chk("rdata", {16'd0, cpu_rdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_req(input logic we, input logic [13:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, output int lat);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    exp_q.push_back(exp_rd);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = k;
        break;
      end
    end
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 14'($urandom);
    cpu_wdata = 16'($urandom);
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no cpu_ready expected one within 60 cycles");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        hit;
    logic        wb;
    logic [13:0] wb_a;
    logic [15:0] wb_d;
    coherency_t  st;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    int nexp;

    vecs[0] = '{we: 1'b0, a: 14'd5,  wd: 16'h0,    rd: 16'd6,    hit: 1'b0, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohS};
    vecs[1] = '{we: 1'b0, a: 14'd5,  wd: 16'h0,    rd: 16'd6,    hit: 1'b1, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohS};
    vecs[2] = '{we: 1'b1, a: 14'd5,  wd: 16'h1234, rd: 16'h0,    hit: 1'b1, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohM};
    vecs[3] = '{we: 1'b0, a: 14'd5,  wd: 16'h0,    rd: 16'h1234, hit: 1'b1, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohM};
    vecs[4] = '{we: 1'b0, a: 14'd13, wd: 16'h0,    rd: 16'd14,   hit: 1'b0, wb: 1'b1,
                wb_a: 14'd5,  wb_d: 16'h1234, st: CohS};
    vecs[5] = '{we: 1'b1, a: 14'd2,  wd: 16'hBEEF, rd: 16'h0,    hit: 1'b0, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohM};
    vecs[6] = '{we: 1'b0, a: 14'd2,  wd: 16'h0,    rd: 16'hBEEF, hit: 1'b1, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohM};
    vecs[7] = '{we: 1'b1, a: 14'd13, wd: 16'h00AA, rd: 16'h0,    hit: 1'b1, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohM};
    vecs[8] = '{we: 1'b0, a: 14'd5,  wd: 16'h0,    rd: 16'h1234, hit: 1'b0, wb: 1'b1,
                wb_a: 14'd13, wb_d: 16'h00AA, st: CohS};
    vecs[9] = '{we: 1'b0, a: 14'd3,  wd: 16'h0,    rd: 16'd4,    hit: 1'b0, wb: 1'b0,
                wb_a: 14'd0,  wb_d: 16'h0,    st: CohS};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_processor_req", {31'd0, processor_req}, 32'd0);
    chk("rst_rd_wr_req", {30'd0, mem_read_req, mem_write_req}, 32'd0);
    chk("rst_addr", {18'd0, addr}, 32'd0);
    chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_line_state", {30'd0, dut.u_tags.state_q[i]}, {30'd0, CohI});
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      log_q.delete();
      run_req(vecs[v].we, vecs[v].a, vecs[v].wd, vecs[v].rd, lat);
      nexp = vecs[v].hit ? 0 : (vecs[v].wb ? 2 : 1);
      if (vecs[v].hit) chk("hit_latency", lat, 2);
      chk("mem_op_count", log_q.size(), nexp);
      if (!vecs[v].hit && log_q.size() == nexp) begin
        if (vecs[v].wb) begin
          chk("wb_is_write", {31'd0, log_q[0].we}, 32'd1);
          chk("wb_addr", {18'd0, log_q[0].a}, {18'd0, vecs[v].wb_a});
          chk("wb_data", {16'd0, log_q[0].d}, {16'd0, vecs[v].wb_d});
        end
        chk("fill_is_read", {31'd0, log_q[nexp-1].we}, 32'd0);
        chk("fill_addr", {18'd0, log_q[nexp-1].a}, {18'd0, vecs[v].a});
      end
      chk("line_state", {30'd0, dut.u_tags.state_q[vecs[v].a[2:0]]}, {30'd0, vecs[v].st});
    end
    chk("line5_tag_after_wb", {21'd0, dut.u_tags.tag_q[5]}, 32'd0);

    // Reset asserted while a fill is outstanding
    log_q.delete();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'd4;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (processor_req && mem_read_req) begin
        lat = k;
        break;
      end
    end
    chk("fill_started", {31'd0, lat != 0}, 32'd1);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midfill_rst_processor_req", {31'd0, processor_req}, 32'd0);
    chk("midfill_rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("midfill_rst_read_req", {31'd0, mem_read_req}, 32'd0);
    for (int i = 0; i < 8; i++) chk("midfill_line_state", {30'd0, dut.u_tags.state_q[i]}, 32'd0);
    repeat (6) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    log_q.delete();

    // Line 5 held tag 0 before reset; after reset all lines are I so addr 13 misses.
    run_req(1'b0, 14'd13, 16'h0, 16'h00AA, lat);
    chk("post_rst_mem_ops", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("post_rst_fill_is_read", {31'd0, log_q[0].we}, 32'd0);
      chk("post_rst_fill_addr", {18'd0, log_q[0].a}, 32'd13);
    end
    chk("post_rst_line_state", {30'd0, dut.u_tags.state_q[5]}, {30'd0, CohS});
    chk("post_rst_line_tag", {21'd0, dut.u_tags.tag_q[5]}, 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
